sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive data grants, taken while inst_req is pending, after which the next grant SHALL go to inst.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous and active-low; assertion SHALL clear all state immediately, independent of clk.
REQ-004 inst_req / inst_addr  in  1/32  instruction read request and its address.
REQ-005 inst_addr_ok / inst_data_ok  out  1/1  instruction request accepted / instruction read data valid.
REQ-006 inst_rdata  out  32  instruction read data.
REQ-007 data_req / data_wr / data_wstrb / data_addr / data_wdata  in  1/1/4/32/32  data request, write flag, byte strobes, address and write data.
REQ-008 data_addr_ok / data_data_ok / data_rdata  out  1/1/32  data request accepted / data read or write completion / data read data.
REQ-009 mem_req / mem_wr / mem_wstrb / mem_addr / mem_wdata  out  1/1/4/32/32  shared memory port request.
REQ-010 mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  shared memory port accept / completion / read data.

Function
REQ-011 The FSM SHALL have three states: IDLE, REQ and WAIT, and SHALL allow at most one transaction outstanding.
REQ-012 IDLE -> REQ SHALL occur on any cycle with inst_req or data_req high; the owner is latched on that edge.
REQ-013 Owner selection SHALL give priority to data, except inst wins when inst_req=1 and starve_cnt==STARVE_LIMIT.
REQ-014 On the grant edge, the owner's addr, wr, wstrb and wdata SHALL be latched; inst grants latch wr=0 and wstrb=0.
REQ-015 In REQ, mem_req SHALL be 1 and the mem_* fields SHALL come from the latched registers; in IDLE and WAIT, mem_req SHALL be 0.
REQ-016 In REQ with mem_addr_ok=1, the owner's addr_ok SHALL be 1 combinationally in that cycle, and the FSM SHALL move to WAIT.
REQ-017 mem_data_ok SHALL be ignored outside WAIT.
REQ-018 In WAIT with mem_data_ok=1, the owner's data_ok SHALL be 1 combinationally in that cycle, and the FSM SHALL return to IDLE.
REQ-019 The non-owner's addr_ok and data_ok SHALL always be 0.
REQ-020 inst_rdata and data_rdata SHALL both equal mem_rdata at all times; they are meaningful only with the respective data_ok.
REQ-021 Write transactions SHALL also complete through data_data_ok.
REQ-022 Minimum latency: request seen in cycle N -> mem_req in cycle N+1 -> addr_ok no earlier than N+1 -> data_ok no earlier than N+2 -> next grant decision in the cycle after data_ok.
REQ-023 starve_cnt is 0..STARVE_LIMIT: +1 on a data grant with inst_req=1, saturating; cleared to 0 on an inst grant or a data grant with inst_req=0.
REQ-024 A requester SHALL hold its req and fields until its addr_ok.
REQ-025 If a requester drops req early, the arbiter SHALL still complete the latched transaction and return to IDLE.
REQ-026 Requests arriving while in REQ or WAIT SHALL be held off with no addr_ok and SHALL be arbitrated at the next IDLE.

Reset
REQ-027 While resetn=0: state=IDLE, starve_cnt=0, latched addr/wdata/wstrb/wr=0, owner=inst, and mem_req and all addr_ok/data_ok outputs=0.
REQ-028 Deasserting resetn mid-transaction SHALL abandon that transaction; no data_ok SHALL be issued for it after reset.
REQ-029 The first grant after reset SHALL follow REQ-013 with starve_cnt=0.

Verification
REQ-030 Single inst read:
- Stimulus: inst_req=1, addr=0xBFC00000; mem_addr_ok one cycle after mem_req; mem_data_ok two cycles later with rdata=0x3C080001.
- Required: mem_addr=0xBFC00000, mem_wr=0, inst_addr_ok then inst_data_ok each pulse one cycle, inst_rdata=0x3C080001, data_* ok stay 0.
REQ-031 Simultaneous requests:
- Stimulus: inst_req and data_req (write, addr=0x1000, wstrb=0xF, wdata=0xDEADBEEF) rise together.
- Required: data granted first with mem_wr=1 and mem_wdata=0xDEADBEEF; inst granted in the IDLE after data_data_ok; starve_cnt=1, then 0.
REQ-032 Starvation:
- Stimulus: data_req held continuously with inst_req high, STARVE_LIMIT=4.
- Required: grant sequence D,D,D,D,I,D...
REQ-033 Back-pressure:
- Stimulus: mem_addr_ok held 0 for 5 cycles in REQ.
- Required: mem_req and mem_addr held stable, no addr_ok; mem_data_ok pulsed during REQ produces no data_ok.
REQ-034 Async reset:
- Stimulus: resetn pulled low between clock edges while in WAIT.
- Required: mem_req=0 and all ok outputs=0 before the next edge; after release, a fresh data_req is granted normally with no stale data_ok.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master (instruction / data) arbiter onto a single SRAM-like port.
// One transaction outstanding; data has priority with an anti-starvation limit for inst.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic             owner_data;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_wstrb;
  logic             lat_wr;
  logic             grant_data;

  // Data wins unless inst has waited out the full starvation window.
  assign grant_data = data_req && !(inst_req && (starve_cnt == LIMIT_C));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      lat_wr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            state      <= REQ;
            owner_data <= grant_data;
            if (grant_data) begin
              lat_addr  <= data_addr;
              lat_wdata <= data_wdata;
              lat_wstrb <= data_wstrb;
              lat_wr    <= data_wr;
              if (!inst_req)
                starve_cnt <= '0;
              else if (starve_cnt != LIMIT_C)
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
              lat_addr   <= inst_addr;
              lat_wdata  <= '0;
              lat_wstrb  <= '0;
              lat_wr     <= 1'b0;
              starve_cnt <= '0;
            end
          end
        end
        REQ: begin
          if (mem_addr_ok)
            state <= WAIT;
        end
        WAIT: begin
          if (mem_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_wr    = lat_wr;
  assign mem_wstrb = lat_wstrb;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Handshakes are steered to the latched owner only; mem_data_ok is ignored outside WAIT.
  assign inst_addr_ok = (state == REQ)  && mem_addr_ok && !owner_data;
  assign data_addr_ok = (state == REQ)  && mem_addr_ok &&  owner_data;
  assign inst_data_ok = (state == WAIT) && mem_data_ok && !owner_data;
  assign data_data_ok = (state == WAIT) && mem_data_ok &&  owner_data;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, single read, priority, starvation,
// back-pressure and asynchronous reset mid-transaction.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One full transaction from IDLE with requests already pending; checks which master won.
  task automatic do_grant(input string tag, input logic exp_data, input logic [31:0] exp_addr);
    tick();
    settle();
    chk({tag, "_mem_req"}, mem_req, 1'b1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    mem_addr_ok = 1'b1;
    settle();
    chk({tag, "_data_addr_ok"}, data_addr_ok, exp_data);
    chk({tag, "_inst_addr_ok"}, inst_addr_ok, !exp_data);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    tick();
    mem_data_ok = 1'b0;
  endtask

  logic        starve_exp_data [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset state, with activity on every input to prove outputs are forced quiet
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1111_0000;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h2222_0000; data_wdata = 32'h5555_AAAA;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    settle();
    tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk("rst_data_data_ok", data_data_ok, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    tick();
    resetn = 1'b1;

    // Single instruction read
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    settle();
    chk("ird_idle_mem_req", mem_req, 1'b0);
    tick();
    chk("ird_mem_req", mem_req, 1'b1);
    chk("ird_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("ird_mem_wr", mem_wr, 1'b0);
    chk("ird_no_addr_ok_yet", inst_addr_ok, 1'b0);
    tick();
    mem_addr_ok = 1'b1;
    settle();
    chk("ird_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("ird_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    chk("ird_wait_mem_req", mem_req, 1'b0);
    chk("ird_addr_ok_pulse", inst_addr_ok, 1'b0);
    chk("ird_data_ok_early", inst_data_ok, 1'b0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C08_0001;
    settle();
    chk("ird_inst_data_ok", inst_data_ok, 1'b1);
    chk("ird_inst_rdata", inst_rdata, 32'h3C08_0001);
    chk("ird_data_data_ok", data_data_ok, 1'b0);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("ird_data_ok_pulse", inst_data_ok, 1'b0);

    // Simultaneous requests: data write first, then inst
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
    tick();
    chk("sim_mem_addr", mem_addr, 32'h0000_1000);
    chk("sim_mem_wr", mem_wr, 1'b1);
    chk("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sim_mem_wstrb", mem_wstrb, 4'hF);
    chk("sim_starve1", 32'(dut.starve_cnt), 32'd1);
    mem_addr_ok = 1'b1;
    settle();
    chk("sim_data_addr_ok", data_addr_ok, 1'b1);
    chk("sim_inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("sim_data_data_ok", data_data_ok, 1'b1);
    chk("sim_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("sim_idle_mem_req", mem_req, 1'b0);
    tick();
    chk("sim_inst_mem_addr", mem_addr, 32'h0000_2000);
    chk("sim_inst_mem_wr", mem_wr, 1'b0);
    chk("sim_inst_mem_wstrb", mem_wstrb, 4'h0);
    chk("sim_starve0", 32'(dut.starve_cnt), 32'd0);
    mem_addr_ok = 1'b1;
    settle();
    chk("sim_inst_addr_ok2", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("sim_inst_data_ok2", inst_data_ok, 1'b1);
    tick();
    mem_data_ok = 1'b0;

    // Back-pressure in REQ, with a spurious mem_data_ok that must be ignored
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3004;
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_data_ok = (i == 2);
      settle();
      chk("bp_mem_req", mem_req, 1'b1);
      chk("bp_mem_addr", mem_addr, 32'h0000_3004);
      chk("bp_data_addr_ok", data_addr_ok, 1'b0);
      chk("bp_data_data_ok", data_data_ok, 1'b0);
      tick();
    end
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    settle();
    chk("bp_data_addr_ok_final", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    chk("bp_data_data_ok_final", data_data_ok, 1'b1);
    chk("bp_data_rdata", data_rdata, 32'hCAFE_F00D);
    tick();
    mem_data_ok = 1'b0;

    // Starvation: both held, expect D,D,D,D,I,D
    inst_req = 1'b1; inst_addr = 32'h0000_4000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_5000;
    for (int g = 0; g < 6; g++)
      do_grant($sformatf("starve%0d", g), starve_exp_data[g],
               starve_exp_data[g] ? 32'h0000_5000 : 32'h0000_4000);

    // Async reset while in WAIT
    tick();
    mem_addr_ok = 1'b1;
    settle();
    tick();
    mem_addr_ok = 1'b0;
    #3;
    resetn = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_data_data_ok", data_data_ok, 1'b0);
    chk("arst_inst_data_ok", inst_data_ok, 1'b0);
    chk("arst_data_addr_ok", data_addr_ok, 1'b0);
    chk("arst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("arst_starve", 32'(dut.starve_cnt), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    tick();
    resetn = 1'b1;
    inst_req = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_6000;
    data_wdata = 32'h1234_5678; data_wstrb = 4'h3;
    mem_data_ok = 1'b1;
    settle();
    chk("arst_idle_stale_ok", data_data_ok, 1'b0);
    tick();
    chk("arst_fresh_addr", mem_addr, 32'h0000_6000);
    chk("arst_fresh_wstrb", mem_wstrb, 4'h3);
    chk("arst_fresh_wdata", mem_wdata, 32'h1234_5678);
    chk("arst_req_stale_ok", data_data_ok, 1'b0);
    chk("arst_first_starve", 32'(dut.starve_cnt), 32'd1);
    mem_addr_ok = 1'b1;
    settle();
    chk("arst_fresh_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("arst_fresh_data_ok", data_data_ok, 1'b1);
    tick();
    mem_data_ok = 1'b0; inst_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
